rr_priority_arbiter: RTL and testbench

Parametrised N-way arbiter that turns a request vector into a registered one-hot grant, plus a binary index. It sits between shared-resource requesters (bus masters, FIFO readers, channel DMAs) and the resource. The arbiter supports fixed priority, where the highest index wins, and round-robin priority, selected at run time. A granted requester keeps the grant while its request stays high. An optional hold limit prevents starvation.

---
 rtl/rr_priority_arbiter.sv | 147 ++++++++++++++
 tb/tb_rr_priority_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   N-way arbiter. It produces a registered one-hot grant and a binary index.
//   The priority mode is chosen at run time:
//     rr_en = 0 : fixed priority, the highest set index wins.
//     rr_en = 1 : round-robin, searching from ptr downward and wrapping.
//   A holder keeps the grant while its request stays high. If MAX_HOLD > 0,
//   the grant is forced away after MAX_HOLD consecutive cycles, but only when
//   another requester is waiting.
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   req       : request vector, bit i is requester i
//   rr_en     : 1 = round-robin, 0 = fixed priority (sampled at arbitration edges)
//   gnt       : registered one-hot grant, or zero
//   gnt_valid : registered |gnt
//   gnt_idx   : registered index of the granted bit, 0 when idle
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          rr_en,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  localparam int            HW   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HONE = HW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  logic          holding;
  logic          hold_ok;
  logic          arb_load;
  logic [N-1:0]  cand;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  int            arb_p;

  // The holder still requests. If it arbitrates in this state, the cause is
  // a timeout, so the holder is masked and others get a chance first.
  assign holding = (state_q == GRANT) && req[idx_q];
  assign hold_ok = (MAX_HOLD == 0) || (hcnt_q < HMAX);
  assign cand    = holding ? (req & ~gnt_q) : req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_p     = 0;
    if (rr_en) begin
      // Search order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
      for (int s = 0; s < N; s++) begin
        arb_p = (int'(ptr_q) + N - s) % N;
        if (!win_found && cand[arb_p]) begin
          win_found = 1'b1;
          win_idx   = IW'(arb_p);
        end
      end
    end else begin
      // The last set bit found while scanning upward is the highest index.
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
    win_oh = win_found ? (ONE << win_idx) : '0;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    arb_load = 1'b0;
    case (state_q)
      IDLE: if (|req) arb_load = 1'b1;
      GRANT: begin
        if (holding && hold_ok) begin
          hcnt_d = (MAX_HOLD == 0) ? HONE : hcnt_q + HONE;
        end else if (win_found) begin
          arb_load = 1'b1;
        end else if (holding) begin
          // On timeout with no one else waiting, the holder is re-granted
          // without a gap. This is not a new grant, so ptr stays put.
          hcnt_d = HONE;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_load) begin
      state_d = GRANT;
      gnt_d   = win_oh;
      vld_d   = 1'b1;
      idx_d   = win_idx;
      hcnt_d  = HONE;
      // The new winner becomes the lowest priority for the next search.
      if (rr_en) ptr_d = (win_idx == '0) ? LAST : win_idx - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= LAST;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter
//   Directed test of rr_priority_arbiter with N=8 and MAX_HOLD=4.
//   Each stimulus cycle queues the grant expected after that edge. A monitor
//   process pops one entry at every falling edge and compares it with the
//   DUT outputs.
module tb_rr_priority_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       rr_en;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;

  typedef struct packed {
    logic [7:0] g;
    logic       v;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rr_priority_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rr_en    (rr_en),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] oh2idx(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle of inputs, queue the grant expected after the next edge,
  // then step past that edge.
  task automatic cyc(input logic [7:0] r, input logic en, input logic rs,
                     input logic [7:0] eg);
    exp_t e;
    req   = r;
    rr_en = en;
    reset = rs;
    e.g   = eg;
    e.v   = |eg;
    e.idx = oh2idx(eg);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (gnt !== e.g || gnt_valid !== e.v || gnt_idx !== e.idx || !$onehot0(gnt)) begin
          errors++;
          $display("FAIL grant #%0d @%0t: got gnt=%h valid=%b idx=%0d, want gnt=%h valid=%b idx=%0d",
                   checks, $time, gnt, gnt_valid, gnt_idx, e.g, e.v, e.idx);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    req = '0; rr_en = 1'b0; reset = 1'b1;

    // Reset with every requester active. The first grant in fixed mode goes
    // to requester 7.
    cyc(8'hFF, 1'b0, 1'b1, 8'h00);
    cyc(8'hFF, 1'b0, 1'b1, 8'h00);
    cyc(8'hFF, 1'b0, 1'b0, 8'h80);

    // Fixed priority. 0x2C: bit 5 wins and holds 4 cycles, then the timeout
    // hands over to bit 3. Clearing bit 3 returns the grant to bit 5.
    for (int i = 0; i < 4; i++) cyc(8'h2C, 1'b0, 1'b0, 8'h20);
    cyc(8'h2C, 1'b0, 1'b0, 8'h08);
    cyc(8'h24, 1'b0, 1'b0, 8'h20);
    cyc(8'h00, 1'b0, 1'b0, 8'h00);

    // Round-robin fairness. ptr is still 7. Grants rotate 7..0, each held 4
    // cycles with no gap, then the rotation wraps to 7.
    for (int g = 7; g >= 0; g--)
      for (int c = 0; c < 4; c++) cyc(8'hFF, 1'b1, 1'b0, 8'(1 << g));
    cyc(8'hFF, 1'b1, 1'b0, 8'h80);

    // Lone requester. The grant stays on bit 0 across repeated timeouts.
    for (int i = 0; i < 20; i++) cyc(8'h01, 1'b1, 1'b0, 8'h01);
    cyc(8'h00, 1'b1, 1'b0, 8'h00);

    // Back-to-back release handovers with no idle cycle.
    cyc(8'h81, 1'b1, 1'b0, 8'h80);
    cyc(8'h81, 1'b1, 1'b0, 8'h80);
    cyc(8'h01, 1'b1, 1'b0, 8'h01);
    cyc(8'h80, 1'b1, 1'b0, 8'h80);
    cyc(8'h00, 1'b1, 1'b0, 8'h00);

    // Reset mid-grant. After reset, ptr returns to 7, so 0x81 picks bit 7.
    // With a stale ptr of 5, bit 0 would win instead.
    cyc(8'h80, 1'b1, 1'b0, 8'h80);
    cyc(8'h40, 1'b1, 1'b0, 8'h40);
    cyc(8'h40, 1'b1, 1'b0, 8'h40);
    cyc(8'h40, 1'b1, 1'b1, 8'h00);
    cyc(8'h81, 1'b1, 1'b0, 8'h80);
    cyc(8'h81, 1'b1, 1'b0, 8'h80);
    cyc(8'h00, 1'b1, 1'b0, 8'h00);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
